// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and defaults for the fetch/hazard control unit
package cpu_ctrl_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_REG_W  = 4;
  localparam int DEF_CNT_W  = 16;

  // Encoding loaded into IF/ID when it is flushed
  localparam logic [15:0] NOP = 16'h0000;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    BR_FLUSH = 2'd2,
    HALTED   = 2'd3
  } state_t;

endpackage

// File: rtl/if_hazard_ctrl_if.sv
// rtl/if_hazard_ctrl_if.sv - hazard inputs from ID/EX and fetch-stage control outputs
interface if_hazard_ctrl_if
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int CNT_W  = DEF_CNT_W
);
  logic              IDEX_memRead;
  logic [REG_W-1:0]  IDEX_rd;
  logic [REG_W-1:0]  IFID_rs;
  logic [REG_W-1:0]  IFID_rt;
  logic              IFID_useRt;
  logic              IFID_halt;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              mem_busy;

  logic              pcWrite;
  logic              pcSel;
  logic [ADDR_W-1:0] branchtoPC;
  logic              IFID_enable;
  logic              flush;
  logic              IDEX_bubble;
  logic              freeze;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // master: the control unit; slave: the pipeline it steers
  modport master (
    input  IDEX_memRead, IDEX_rd, IFID_rs, IFID_rt, IFID_useRt, IFID_halt,
           branch_taken, branch_target, mem_busy,
    output pcWrite, pcSel, branchtoPC, IFID_enable, flush, IDEX_bubble, freeze,
           state, stall_cnt, flush_cnt
  );

  modport slave (
    output IDEX_memRead, IDEX_rd, IFID_rs, IFID_rt, IFID_useRt, IFID_halt,
           branch_taken, branch_target, mem_busy,
    input  pcWrite, pcSel, branchtoPC, IFID_enable, flush, IDEX_bubble, freeze,
           state, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/if_hazard_ctrl.sv
// rtl/if_hazard_ctrl.sv - PC/IF-ID control: load-use stall, branch flush, halt, memory freeze
module if_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic              clk,
  input logic              rst,
  if_hazard_ctrl_if.master bus
);

  state_t state, stateNext;

  logic [REG_W-1:0]  exRd;
  logic [ADDR_W-1:0] target;
  logic loadUse;
  logic pcWriteC, pcSelC, ifidEnC, flushC, bubbleC, freezeC;
  logic stallInc, flushInc;

  assign exRd    = bus.IDEX_rd;
  assign target  = bus.branch_target;
  assign loadUse = bus.IDEX_memRead && (exRd != '0) &&
                   ((exRd == bus.IFID_rs) || (bus.IFID_useRt && (exRd == bus.IFID_rt)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    pcWriteC  = 1'b0;
    pcSelC    = 1'b0;
    ifidEnC   = 1'b0;
    flushC    = 1'b0;
    bubbleC   = 1'b0;
    freezeC   = 1'b0;
    stallInc  = 1'b0;
    flushInc  = 1'b0;
    if (bus.mem_busy) begin
      freezeC  = 1'b1;
      stallInc = (state != HALTED);
    end else if (state == HALTED) begin
      bubbleC = 1'b1;
    end else if (bus.branch_taken) begin
      // ID holds a wrong-path instruction, so any halt/load-use there is moot
      pcWriteC  = 1'b1;
      pcSelC    = 1'b1;
      ifidEnC   = 1'b1;
      flushC    = 1'b1;
      bubbleC   = 1'b1;
      flushInc  = 1'b1;
      stateNext = BR_FLUSH;
    end else if (state == BR_FLUSH) begin
      // second slot: the registered imem still returns a wrong-path word
      pcWriteC  = 1'b1;
      ifidEnC   = 1'b1;
      flushC    = 1'b1;
      bubbleC   = 1'b1;
      stateNext = RUN;
    end else if ((state == RUN) && bus.IFID_halt) begin
      bubbleC   = 1'b1;
      stateNext = HALTED;
    end else if ((state == RUN) && loadUse) begin
      bubbleC   = 1'b1;
      stallInc  = 1'b1;
      stateNext = LU_STALL;
    end else begin
      pcWriteC  = 1'b1;
      ifidEnC   = 1'b1;
      stateNext = RUN;
    end
  end

  // Reset overrides outputs combinationally so they are safe before any edge
  assign bus.pcWrite     = rst & pcWriteC;
  assign bus.pcSel       = rst & pcSelC;
  assign bus.IFID_enable = rst & ifidEnC;
  assign bus.flush       = ~rst | flushC;
  assign bus.IDEX_bubble = ~rst | bubbleC;
  assign bus.freeze      = rst & freezeC;
  assign bus.branchtoPC  = bus.pcSel ? target : '0;
  assign bus.state       = state;

  sat_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stallInc),
    .count (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flushInc),
    .count (bus.flush_cnt)
  );

endmodule

// File: tb/tb_if_hazard_ctrl.sv
// tb/tb_if_hazard_ctrl.sv - directed vectors with a queue-based scoreboard for if_hazard_ctrl
module tb_if_hazard_ctrl;
  import cpu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_hazard_ctrl_if bus ();

  if_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [55:0] expQ[$];
  string       nameQ[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [55:0] pack(input logic pw, ps, input logic [15:0] bp,
                                       input logic en, fl, bb, fz, input logic [1:0] st,
                                       input logic [15:0] sc, fc);
    return {pw, ps, bp, en, fl, bb, fz, st, sc, fc};
  endfunction

  // Queue expected outputs for the current cycle, then advance to just after the next edge
  task automatic step(input string n, input logic pw, ps, input logic [15:0] bp,
                      input logic en, fl, bb, fz, input logic [1:0] st,
                      input logic [15:0] sc, fc);
    expQ.push_back(pack(pw, ps, bp, en, fl, bb, fz, st, sc, fc));
    nameQ.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.IDEX_memRead  = 1'b0;
    bus.IDEX_rd       = '0;
    bus.IFID_rs       = '0;
    bus.IFID_rt       = '0;
    bus.IFID_useRt    = 1'b0;
    bus.IFID_halt     = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.mem_busy      = 1'b0;
  endtask

  task automatic setLoadUse(input logic [3:0] rd, rs);
    bus.IDEX_memRead = 1'b1;
    bus.IDEX_rd      = rd;
    bus.IFID_rs      = rs;
  endtask

  task automatic setBranch(input logic [15:0] tgt);
    bus.branch_taken  = 1'b1;
    bus.branch_target = tgt;
  endtask

  initial begin : monitor
    logic [55:0] got, exp;
    string n;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        exp = expQ.pop_front();
        n   = nameQ.pop_front();
        got = {bus.pcWrite, bus.pcSel, bus.branchtoPC, bus.IFID_enable, bus.flush,
               bus.IDEX_bubble, bus.freeze, bus.state, bus.stall_cnt, bus.flush_cnt};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h (pcW,pcS,bPC,en,fl,bub,frz,st,scnt,fcnt)",
                   n, got, exp);
        end
      end
    end
  end

  initial begin : driver
    clearInputs();
    @(posedge clk);
    #1;
    step("reset_forced", 0, 0, 16'h0, 0, 1, 1, 0, RUN, 16'd0, 16'd0);
    rst = 1'b1;
    step("run_idle",     1, 0, 16'h0, 1, 0, 0, 0, RUN, 16'd0, 16'd0);

    setLoadUse(4'd3, 4'd3);
    step("lu_detect",    0, 0, 16'h0, 0, 0, 1, 0, RUN,      16'd0, 16'd0);
    step("lu_stall",     1, 0, 16'h0, 1, 0, 0, 0, LU_STALL, 16'd1, 16'd0);
    clearInputs();
    step("lu_done",      1, 0, 16'h0, 1, 0, 0, 0, RUN,      16'd1, 16'd0);

    setLoadUse(4'd0, 4'd0);
    step("rd_zero",      1, 0, 16'h0, 1, 0, 0, 0, RUN, 16'd1, 16'd0);
    setLoadUse(4'd5, 4'd2);
    bus.IFID_rt = 4'd5;
    step("rt_unused",    1, 0, 16'h0, 1, 0, 0, 0, RUN, 16'd1, 16'd0);
    bus.IFID_useRt = 1'b1;
    step("rt_used",      0, 0, 16'h0, 0, 0, 1, 0, RUN,      16'd1, 16'd0);
    clearInputs();
    step("rt_stall",     1, 0, 16'h0, 1, 0, 0, 0, LU_STALL, 16'd2, 16'd0);

    setBranch(16'h0040);
    step("br_taken",     1, 1, 16'h0040, 1, 1, 1, 0, RUN,      16'd2, 16'd0);
    clearInputs();
    step("br_flush2",    1, 0, 16'h0,    1, 1, 1, 0, BR_FLUSH, 16'd2, 16'd1);
    step("br_done",      1, 0, 16'h0,    1, 0, 0, 0, RUN,      16'd2, 16'd1);

    setLoadUse(4'd3, 4'd3);
    bus.IFID_halt = 1'b1;
    setBranch(16'h0100);
    step("br_over_lu",   1, 1, 16'h0100, 1, 1, 1, 0, RUN,      16'd2, 16'd1);
    setBranch(16'h0200);
    step("br_rebranch",  1, 1, 16'h0200, 1, 1, 1, 0, BR_FLUSH, 16'd2, 16'd2);
    clearInputs();
    step("br_tail",      1, 0, 16'h0,    1, 1, 1, 0, BR_FLUSH, 16'd2, 16'd3);
    step("br_run",       1, 0, 16'h0,    1, 0, 0, 0, RUN,      16'd2, 16'd3);

    setBranch(16'h0080);
    step("br_pre_busy",  1, 1, 16'h0080, 1, 1, 1, 0, RUN, 16'd2, 16'd3);
    clearInputs();
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++)
      step("br_busy",    0, 0, 16'h0, 0, 0, 0, 1, BR_FLUSH, 16'(2 + i), 16'd4);
    bus.mem_busy = 1'b0;
    step("br_resume",    1, 0, 16'h0, 1, 1, 1, 0, BR_FLUSH, 16'd6, 16'd4);
    step("br_resumed",   1, 0, 16'h0, 1, 0, 0, 0, RUN,      16'd6, 16'd4);

    setLoadUse(4'd7, 4'd7);
    step("lu2_detect",   0, 0, 16'h0, 0, 0, 1, 0, RUN,      16'd6, 16'd4);
    bus.mem_busy = 1'b1;
    step("lu2_busy",     0, 0, 16'h0, 0, 0, 0, 1, LU_STALL, 16'd7, 16'd4);
    bus.mem_busy = 1'b0;
    step("lu2_resume",   1, 0, 16'h0, 1, 0, 0, 0, LU_STALL, 16'd8, 16'd4);
    clearInputs();
    step("lu2_run",      1, 0, 16'h0, 1, 0, 0, 0, RUN,      16'd8, 16'd4);

    bus.IFID_halt = 1'b1;
    step("halt_enter",   0, 0, 16'h0, 0, 0, 1, 0, RUN, 16'd8, 16'd4);
    for (int i = 0; i < 10; i++) begin
      bus.branch_taken  = i[0];
      bus.branch_target = 16'h1234;
      step("halted",     0, 0, 16'h0, 0, 0, 1, 0, HALTED, 16'd8, 16'd4);
    end
    clearInputs();
    bus.mem_busy = 1'b1;
    step("halt_busy",    0, 0, 16'h0, 0, 0, 0, 1, HALTED, 16'd8, 16'd4);
    step("halt_busy2",   0, 0, 16'h0, 0, 0, 0, 1, HALTED, 16'd8, 16'd4);
    bus.mem_busy = 1'b0;

    rst = 1'b0;
    step("rst_async",    0, 0, 16'h0, 0, 1, 1, 0, RUN, 16'd0, 16'd0);
    rst = 1'b1;
    step("rst_release",  1, 0, 16'h0, 1, 0, 0, 0, RUN, 16'd0, 16'd0);

    bus.mem_busy = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    step("sat_fffe",     0, 0, 16'h0, 0, 0, 0, 1, RUN, 16'hFFFE, 16'd0);
    step("sat_ffff",     0, 0, 16'h0, 0, 0, 0, 1, RUN, 16'hFFFF, 16'd0);
    step("sat_hold",     0, 0, 16'h0, 0, 0, 0, 1, RUN, 16'hFFFF, 16'd0);
    step("sat_hold2",    0, 0, 16'h0, 0, 0, 0, 1, RUN, 16'hFFFF, 16'd0);
    bus.mem_busy = 1'b0;

    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
